// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the FIR MAC sequencer: state encoding,
// default geometry and the DRAIN counter width.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_t;

  localparam int TAPS_DEF    = 4;
  localparam int DW_DEF      = 16;
  localparam int MAC_LAT_DEF = 2;

  // Wide enough for MAC pipelines up to 16 cycles deep.
  localparam int DRAIN_CW = 4;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Bus between the FIR sequencer and its neighbours: sample input handshake,
// sample RAM / coefficient ROM ports, MAC strobes and result handshake.
interface fir_mac_sequencer_if #(
  parameter int AW = 2,
  parameter int DW = 16
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is held with stable data until that edge, and ready may
  // only be acted on together with valid.
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_sample;
  logic          smp_we;
  logic [AW-1:0] smp_waddr;
  logic [DW-1:0] smp_wdata;
  logic [AW-1:0] smp_raddr;
  logic [AW-1:0] coef_raddr;
  logic          mac_clr;
  logic          mac_en;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  in_valid, in_sample, out_ready,
    output in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_raddr,
           mac_clr, mac_en, out_valid
  );

  modport slave (
    output in_valid, in_sample, out_ready,
    input  in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_raddr,
           mac_clr, mac_en, out_valid
  );

endinterface

// File: rtl/fir_seq_addr_gen.sv
// Address generator: circular write pointer, current-sample latch and tap
// counter; produces the sample/coefficient read addresses for each MAC step.
module fir_seq_addr_gen #(
  parameter int AW = 2
) (
  input  logic          system1000,
  input  logic          system1000_rstn,
  input  logic          accept,
  input  logic          step,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] smp_raddr,
  output logic [AW-1:0] coef_raddr,
  output logic          last_tap
);

  logic [AW-1:0] cur;
  logic [AW-1:0] k;

  // All three counters are AW bits wide, so TAPS-1 -> 0 wraps by overflow.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      wptr <= '0;
      cur  <= '0;
      k    <= '0;
    end else if (accept) begin
      cur  <= wptr;
      wptr <= wptr + AW'(1);
      k    <= '0;
    end else if (step) begin
      k <= k + AW'(1);
    end
  end

  assign last_tap   = step & (k == '1);
  assign smp_raddr  = step ? (cur - k) : '0;
  assign coef_raddr = step ? k : '0;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: FLUSH -> IDLE -> MAC -> DRAIN -> HOLD.
// Optional FIR_SEQ_STALL_CNT_EN adds a saturating output backpressure counter.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int AW      = $clog2(TAPS),
  parameter int DW      = DW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                 system1000,
  input  logic                 system1000_rstn,
`ifdef FIR_SEQ_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  output seq_state_t           dbg_state,
  fir_mac_sequencer_if.master  bus
);

  seq_state_t            state;
  logic [AW:0]           fcnt;
  logic [DRAIN_CW-1:0]   dcnt;
  logic                  flush_we_q;
  logic [AW-1:0]         flush_addr_q;
  logic                  in_ready_q;
  logic                  mac_en_q;
  logic                  mac_clr_q;
  logic                  out_valid_q;
  logic                  accept;
  logic                  last_tap;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         smp_raddr;
  logic [AW-1:0]         coef_raddr;
  logic [DW-1:0]         wdata;

  assign accept = bus.in_valid & in_ready_q;

  fir_seq_addr_gen #(.AW(AW)) u_addr_gen (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .accept          (accept),
    .step            (mac_en_q),
    .wptr            (wptr),
    .smp_raddr       (smp_raddr),
    .coef_raddr      (coef_raddr),
    .last_tap        (last_tap)
  );

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      state        <= ST_FLUSH;
      fcnt         <= '0;
      dcnt         <= '0;
      flush_we_q   <= 1'b0;
      flush_addr_q <= '0;
      in_ready_q   <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_FLUSH: begin
          if (fcnt == (AW+1)'(TAPS)) begin
            state        <= ST_IDLE;
            flush_we_q   <= 1'b0;
            flush_addr_q <= '0;
            in_ready_q   <= 1'b1;
          end else begin
            flush_we_q   <= 1'b1;
            flush_addr_q <= fcnt[AW-1:0];
            fcnt         <= fcnt + (AW+1)'(1);
          end
        end
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_MAC;
            in_ready_q <= 1'b0;
            mac_en_q   <= 1'b1;
            mac_clr_q  <= 1'b1;
          end
        end
        ST_MAC: begin
          mac_clr_q <= 1'b0;
          if (last_tap) begin
            state    <= ST_DRAIN;
            mac_en_q <= 1'b0;
            dcnt     <= '0;
          end
        end
        ST_DRAIN: begin
          if (dcnt == DRAIN_CW'(MAC_LAT - 1)) begin
            state       <= ST_HOLD;
            out_valid_q <= 1'b1;
          end else begin
            dcnt <= dcnt + DRAIN_CW'(1);
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

  // The accepted sample goes straight to the RAM in its handshake cycle.
  assign wdata          = accept ? bus.in_sample : '0;
  assign bus.in_ready   = in_ready_q;
  assign bus.smp_we     = flush_we_q | accept;
  assign bus.smp_waddr  = flush_we_q ? flush_addr_q : (accept ? wptr : '0);
  assign bus.smp_wdata  = wdata;
  assign bus.smp_raddr  = smp_raddr;
  assign bus.coef_raddr = coef_raddr;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.out_valid  = out_valid_q;
  assign dbg_state      = state;

`ifdef FIR_SEQ_STALL_CNT_EN
  // Counts every HOLD cycle refused by the consumer; cleared only by reset.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      stall_cnt <= '0;
    end else if ((state == ST_HOLD) && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Backpressure is not tracked in this build.
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed timing steps plus random traffic,
// with a RAM/MAC datapath model and an FIR reference (coefficients 2,3,-2,8).
module tb_fir_mac_sequencer;
  import fir_seq_pkg::*;

  localparam int TAPS = 4;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int MAC_LAT = 2;

  logic system1000 = 1'b0;
  logic system1000_rstn = 1'b0;
  seq_state_t dbg_state;
`ifdef FIR_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fir_mac_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  fir_mac_sequencer #(.TAPS(TAPS), .AW(AW), .DW(DW), .MAC_LAT(MAC_LAT)) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
`ifdef FIR_SEQ_STALL_CNT_EN
    .stall_cnt       (stall_cnt),
`endif
    .dbg_state       (dbg_state),
    .bus             (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 system1000 = ~system1000;

  // ---------------- out_ready source ----------------
  logic or_fixed = 1'b0;
  logic or_rand_en = 1'b0;
  logic or_rand = 1'b0;
  assign bus.out_ready = or_rand_en ? or_rand : or_fixed;
  always @(negedge system1000) or_rand = 1'($urandom_range(0, 1));

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  int coef [TAPS] = '{2, 3, -2, 8};
  int hist [TAPS];
  int ram [TAPS];
  int acc = 0;
  int cyc = 0;
  int last_acc = 0;
  int wptr_m = 0;
  int stall_m = 0;
  int n_acc = 0;
  int y;
  logic last_acc_chk = 1'b0;
  logic chk_spacing = 1'b0;
  logic ov_prev = 1'b0;
  logic or_prev = 1'b0;
  logic signed [31:0] exp_q [$];
  logic signed [31:0] got_q [$];
  logic signed [31:0] exp_v;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: observed timeout expected event", tag);
  endtask

  // Monitor: samples mid-cycle, models RAM + MAC and the ideal FIR result.
  always begin
    @(negedge system1000);
    #2;
    cyc++;
`ifdef FIR_SEQ_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_m);
`endif
    if (!system1000_rstn) begin
      for (int i = 0; i < TAPS; i++) hist[i] = 0;
      wptr_m = 0;
      exp_q.delete();
      got_q.delete();
      ov_prev = 1'b0;
      or_prev = 1'b0;
      stall_m = 0;
      last_acc_chk = 1'b0;
    end else begin
      if (ov_prev && !or_prev) check("ov_hold", bus.out_valid, 1);
      if (bus.out_valid && !ov_prev) check("latency", cyc - last_acc, TAPS + MAC_LAT + 1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result: observed unexpected result %0d expected none", acc);
        end else begin
          exp_v = exp_q.pop_front();
          check("result", acc, exp_v);
          got_q.push_back(acc);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        check("acc_state", dbg_state, ST_IDLE);
        check("acc_waddr", bus.smp_waddr, wptr_m);
        check("acc_wdata", bus.smp_wdata, bus.in_sample);
        if (chk_spacing && last_acc_chk) check("spacing", cyc - last_acc, TAPS + MAC_LAT + 2);
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'($signed(bus.in_sample));
        y = 0;
        for (int i = 0; i < TAPS; i++) y += coef[i] * hist[i];
        exp_q.push_back(y);
        last_acc = cyc;
        last_acc_chk = chk_spacing;
        wptr_m = (wptr_m + 1) % TAPS;
        n_acc++;
      end
      if (bus.mac_en) acc = (bus.mac_clr ? 0 : acc) + coef[bus.coef_raddr] * ram[bus.smp_raddr];
      if (bus.smp_we) ram[bus.smp_waddr] = int'($signed(bus.smp_wdata));
      if (bus.out_valid && !bus.out_ready && stall_m != 65535) stall_m++;
      ov_prev = bus.out_valid;
      or_prev = bus.out_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_quiet(input string tag);
    check({tag, "_we"}, bus.smp_we, 0);
    check({tag, "_waddr"}, bus.smp_waddr, 0);
    check({tag, "_wdata"}, bus.smp_wdata, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_mac_en"}, bus.mac_en, 0);
    check({tag, "_mac_clr"}, bus.mac_clr, 0);
    check({tag, "_raddr"}, bus.smp_raddr, 0);
    check({tag, "_coef"}, bus.coef_raddr, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_state"}, dbg_state, ST_FLUSH);
  endtask

  task automatic flush_checks();
    for (int i = 0; i < TAPS; i++) begin
      @(negedge system1000);
      #1;
      check("flush_we", bus.smp_we, 1);
      check("flush_waddr", bus.smp_waddr, i);
      check("flush_wdata", bus.smp_wdata, 0);
      check("flush_in_ready", bus.in_ready, 0);
    end
    @(negedge system1000);
    #1;
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_we", bus.smp_we, 0);
    check("idle_state", dbg_state, ST_IDLE);
  endtask

  task automatic do_reset();
    @(negedge system1000);
    system1000_rstn = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge system1000);
    #1;
    check_quiet("rst");
    system1000_rstn = 1'b1;
    flush_checks();
  endtask

  task automatic send(input logic [DW-1:0] s, output logic [AW-1:0] wa);
    int g = 0;
    wa = '0;
    @(negedge system1000);
    while (!bus.in_ready && g < 100) begin
      @(negedge system1000);
      g++;
    end
    if (!bus.in_ready) begin
      timeout("send");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_sample = s;
    #1;
    wa = bus.smp_waddr;
    check("send_we", bus.smp_we, 1);
    @(negedge system1000);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int budget);
    int g = 0;
    do begin
      @(negedge system1000);
      #1;
      g++;
    end while (!bus.out_valid && g < budget);
    if (!bus.out_valid) timeout("wait_out_valid");
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    do begin
      @(negedge system1000);
      #1;
      g++;
    end while (!(exp_q.size() == 0 && bus.in_ready) && g < budget);
    if (!(exp_q.size() == 0 && bus.in_ready)) timeout("wait_drain");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [AW-1:0] wa;
    int exp_raddr [TAPS] = '{0, 3, 2, 1};
    int imp_exp [5] = '{2, 3, -2, 8, 0};
    int imp_in [5] = '{1, 0, 0, 0, 0};
    int start_acc;
    int g;

    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    do_reset();

    // Single sample 1: strobe timing, addresses and result 2.
    send(16'd1, wa);
    check("a_waddr", wa, 0);
    for (int j = 0; j < TAPS; j++) begin
      #1;
      check("a_mac_en", bus.mac_en, 1);
      check("a_mac_clr", bus.mac_clr, (j == 0) ? 1 : 0);
      check("a_raddr", bus.smp_raddr, exp_raddr[j]);
      check("a_coef", bus.coef_raddr, j);
      check("a_in_ready", bus.in_ready, 0);
      @(negedge system1000);
    end
    #1;
    check("a_drain_en", bus.mac_en, 0);
    check("a_drain_ov", bus.out_valid, 0);
    @(negedge system1000);
    #1;
    check("a_drain2_ov", bus.out_valid, 0);
    @(negedge system1000);
    #1;
    check("a_ov", bus.out_valid, 1);
    check("a_hold", dbg_state, ST_HOLD);
    or_fixed = 1'b1;
    @(negedge system1000);
    #1;
    check("a_ov_done", bus.out_valid, 0);
    check("a_ready_back", bus.in_ready, 1);
    if (got_q.size() > 0) check("a_result", got_q[got_q.size()-1], 2);
    else timeout("a_result");

    // Backpressure: ten refused HOLD cycles.
    or_fixed = 1'b0;
    send(16'($urandom), wa);
    wait_out_valid(30);
    for (int i = 0; i < 10; i++) begin
      check("b_ov", bus.out_valid, 1);
      check("b_in_ready", bus.in_ready, 0);
      @(negedge system1000);
      #1;
    end
`ifdef FIR_SEQ_STALL_CNT_EN
    check("b_stall10", stall_cnt, 10);
`endif
    or_fixed = 1'b1;
    @(negedge system1000);
    #1;
    check("b_ov_done", bus.out_valid, 0);

    // Impulse response and write-pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'(imp_in[i]), wa);
      check("c_waddr", wa, i % TAPS);
    end
    wait_drain(100);
    check("c_count", got_q.size(), 5);
    if (got_q.size() == 5)
      for (int i = 0; i < 5; i++) check("c_impulse", got_q[i], imp_exp[i]);

    // Reset during MAC at k=2 aborts the result.
    send(16'($urandom), wa);
    @(negedge system1000);
    @(negedge system1000);
    #1;
    check("d_coef_k2", bus.coef_raddr, 2);
    check("d_mac_en", bus.mac_en, 1);
    system1000_rstn = 1'b0;
    @(negedge system1000);
    #1;
    check_quiet("abort");
    system1000_rstn = 1'b1;
    flush_checks();
    repeat (12) @(negedge system1000);
    #1;
    check("d_no_result", got_q.size(), 0);

    // Continuous in_valid: one accept per TAPS+MAC_LAT+2 cycles.
    chk_spacing = 1'b1;
    start_acc = n_acc;
    g = 0;
    @(negedge system1000);
    bus.in_valid = 1'b1;
    while (n_acc - start_acc < 6 && g < 100) begin
      bus.in_sample = 16'($urandom);
      @(negedge system1000);
      g++;
    end
    bus.in_valid = 1'b0;
    check("e_accepts", n_acc - start_acc, 6);
    wait_drain(100);
    chk_spacing = 1'b0;

    // Random samples, gaps and consumer backpressure.
    or_rand_en = 1'b1;
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge system1000);
      send(16'($urandom), wa);
    end
    wait_drain(600);
    or_rand_en = 1'b0;
    check("f_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
